kbd_input_port: RTL and testbench

//  Input-device end of the eLC-3 KBSR/KBDR keyboard handshake. Debounces a pushbutton; each press

---
 rtl/elc3_pkg.sv | 27 ++
 rtl/key_debouncer.sv | 76 +++++++
 rtl/kbd_input_port.sv | 131 +++++++++++++
 tb/tb_kbd_input_port.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elc3_pkg.sv
// rtl/elc3_pkg.sv - eLC-3 keyboard port addresses, KBSR bit positions and debouncer state type
package elc3_pkg;

    localparam logic [15:0] KBSR_ADDR      = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR      = 16'hFE02;
    localparam int          KBSR_READY_BIT = 15;
    localparam int          KBSR_IE_BIT    = 14;
    localparam int          KBSR_OVR_BIT   = 13;

    typedef enum logic [1:0] {
        DEB_RELEASED     = 2'd0,
        DEB_PRESS_WAIT   = 2'd1,
        DEB_PRESSED      = 2'd2,
        DEB_RELEASE_WAIT = 2'd3
    } kbd_deb_state_t;

    // Assemble the status word; every bit not named here reads as zero.
    function automatic logic [15:0] kbsr_pack(input logic ready, input logic ie, input logic ovr);
        logic [15:0] w;
        w                 = '0;
        w[KBSR_READY_BIT] = ready;
        w[KBSR_IE_BIT]    = ie;
        w[KBSR_OVR_BIT]   = ovr;
        return w;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - pushbutton debouncer emitting one Press pulse per accepted press
module key_debouncer
    import elc3_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Key_N,
    output logic Press
);

    localparam logic [15:0] LAST_COUNT = DEBOUNCE_CYCLES - 16'd1;

    kbd_deb_state_t state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;

    // State and stability counter register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= DEB_RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a level change is accepted only after DEBOUNCE_CYCLES stable samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            DEB_RELEASED: begin
                cnt_d = '0;
                if (!Key_N) state_d = DEB_PRESS_WAIT;
            end
            DEB_PRESS_WAIT: begin
                if (Key_N) begin
                    state_d = DEB_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_COUNT) begin
                    state_d = DEB_PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DEB_PRESSED: begin
                cnt_d = '0;
                if (Key_N) state_d = DEB_RELEASE_WAIT;
            end
            DEB_RELEASE_WAIT: begin
                if (!Key_N) begin
                    state_d = DEB_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_COUNT) begin
                    state_d = DEB_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = DEB_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Output: pulse in the single cycle the press is accepted
    always_comb begin
        Press = (state_q == DEB_PRESS_WAIT) && !Key_N && (cnt_q == LAST_COUNT);
    end

endmodule

// File: rtl/kbd_input_port.sv
// rtl/kbd_input_port.sv - KBSR/KBDR keyboard input port with press FIFO; KBD_IRQ_EN adds IE bit and Irq
module kbd_input_port
    import elc3_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          FIFO_DEPTH      = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Key_N,
    input  logic [15:0] Switches,
    input  logic        Rd_KBDR,
    input  logic        Wr_KBSR,
    input  logic [15:0] Wr_Data,
    output logic [15:0] KBSR,
`ifdef KBD_IRQ_EN
    output logic [15:0] KBDR,
    output logic        Irq
`else
    output logic [15:0] KBDR
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              press;
    logic              pop_acc, push_acc, full, ovr_set;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovr_q, ovr_d;
    logic              ie_d;
    logic [15:0]       kbsr_q, kbsr_d, kbdr_q, kbdr_d;
    logic [15:0]       mem_q [FIFO_DEPTH];
    logic              unused_wr_data;

    // Only the IE bit of a KBSR write carries data; the rest of the word is a clear strobe.
    assign unused_wr_data = ^Wr_Data;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .Clk   (Clk),
        .Reset (Reset),
        .Key_N (Key_N),
        .Press (press)
    );

`ifdef KBD_IRQ_EN
    logic ie_q;
    logic irq_q;

    // Interrupt enable follows bit 14 of every KBSR write
    always_comb begin
        ie_d = Wr_KBSR ? Wr_Data[KBSR_IE_BIT] : ie_q;
    end

    // IE and registered interrupt; Irq trails the visible KBSR bits by one cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= ie_q & (count_q != '0);
        end
    end

    assign Irq = irq_q;
`else
    // Without interrupt support the IE bit is hard-wired to zero
    always_comb begin
        ie_d = 1'b0;
    end
`endif

    // FIFO control: pop wins a slot even when full, so push+pop never overruns
    always_comb begin
        pop_acc  = Rd_KBDR && (count_q != '0);
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        push_acc = press && (!full || pop_acc);
        ovr_set  = press && full && !pop_acc;
        head_d   = pop_acc  ? head_q + PTR_W'(1) : head_q;
        tail_d   = push_acc ? tail_q + PTR_W'(1) : tail_q;
        count_d  = count_q;
        if (push_acc && !pop_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_acc && !push_acc) begin
            count_d = count_q - CNT_W'(1);
        end
        ovr_d = ovr_set | (ovr_q & ~Wr_KBSR);
        if (count_d == '0) begin
            kbdr_d = '0;
        end else if (push_acc && (head_d == tail_q)) begin
            kbdr_d = Switches;
        end else begin
            kbdr_d = mem_q[head_d];
        end
        kbsr_d = kbsr_pack(count_d != '0, ie_d, ovr_d);
    end

    // Pointers, occupancy, overrun and the registered KBSR/KBDR views
    always_ff @(posedge Clk) begin
        if (Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            kbsr_q  <= '0;
            kbdr_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            kbsr_q  <= kbsr_d;
            kbdr_q  <= kbdr_d;
        end
    end

    // FIFO storage; contents are only observed while counted as valid
    always_ff @(posedge Clk) begin
        if (push_acc) begin
            mem_q[tail_q] <= Switches;
        end
    end

    assign KBSR = kbsr_q;
    assign KBDR = kbdr_q;

endmodule

// File: tb/tb_kbd_input_port.sv
// tb/tb_kbd_input_port.sv - self-checking bench for kbd_input_port against a behavioural model
module tb_kbd_input_port;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic        Clk;
    logic        Reset;
    logic        Key_N;
    logic [15:0] Switches;
    logic        Rd_KBDR;
    logic        Wr_KBSR;
    logic [15:0] Wr_Data;
    logic [15:0] KBSR;
    logic [15:0] KBDR;
`ifdef KBD_IRQ_EN
    logic        Irq;
`endif

    kbd_input_port #(
        .DEBOUNCE_CYCLES(16'(D)),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Key_N    (Key_N),
        .Switches (Switches),
        .Rd_KBDR  (Rd_KBDR),
        .Wr_KBSR  (Wr_KBSR),
        .Wr_Data  (Wr_Data),
        .KBSR     (KBSR),
`ifdef KBD_IRQ_EN
        .KBDR     (KBDR),
        .Irq      (Irq)
`else
        .KBDR     (KBDR)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q_m[$];
    bit          ovr_m, ie_m, irq_m, pressed_m;
    int          run_m;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        ovr_m     = 0;
        ie_m      = 0;
        irq_m     = 0;
        pressed_m = 0;
        run_m     = 0;
    endtask

    task automatic check_model();
        logic [15:0] ek, ed;
        ek     = '0;
        ek[15] = (q_m.size() != 0);
        ek[14] = ie_m;
        ek[13] = ovr_m;
        ed     = (q_m.size() != 0) ? q_m[0] : 16'h0000;
        chk("model_kbsr", KBSR, ek);
        chk("model_kbdr", KBDR, ed);
`ifdef KBD_IRQ_EN
        chk("model_irq", {15'd0, Irq}, {15'd0, irq_m});
`endif
    endtask

    // One clock with the given inputs; the model advances on the same edge as the DUT.
    task automatic tick(input logic key, input logic [15:0] sw, input logic rd,
                        input logic wr, input logic [15:0] wd);
        bit ev, pop, new_ovr, irq_next;
        Key_N = key; Switches = sw; Rd_KBDR = rd; Wr_KBSR = wr; Wr_Data = wd;
        @(posedge Clk);
        irq_next = ie_m && (q_m.size() != 0);
        ev = 0;
        if (pressed_m ? (key == 1'b1) : (key == 1'b0)) run_m++;
        else run_m = 0;
        if (run_m == D + 1) begin
            pressed_m = !pressed_m;
            run_m     = 0;
            ev        = pressed_m;
        end
        pop     = rd && (q_m.size() != 0);
        new_ovr = 0;
        if (ev && pop) begin
            void'(q_m.pop_front());
            q_m.push_back(sw);
        end else if (pop) begin
            void'(q_m.pop_front());
        end else if (ev) begin
            if (q_m.size() < DEPTH) q_m.push_back(sw);
            else new_ovr = 1;
        end
        if (wr) begin
            ovr_m = 0;
`ifdef KBD_IRQ_EN
            ie_m = wd[14];
`endif
        end
        if (new_ovr) ovr_m = 1;
        irq_m = irq_next;
        #1;
        check_model();
    endtask

    task automatic do_reset(input int n, input logic key);
        Reset = 1'b1; Key_N = key; Switches = '0; Rd_KBDR = 0; Wr_KBSR = 0; Wr_Data = '0;
        repeat (n) @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        check_model();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic hold_low(input int n, input logic [15:0] sw);
        repeat (n) tick(1'b0, sw, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic press(input logic [15:0] sw);
        hold_low(D + 2, sw);
        idle(D + 2);
    endtask

    task automatic pop1();
        tick(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic wr_kbsr(input logic [15:0] wd);
        tick(1'b1, 16'h0000, 1'b0, 1'b1, wd);
    endtask

    initial begin
        Reset = 1'b1; Key_N = 1'b1; Switches = '0; Rd_KBDR = 0; Wr_KBSR = 0; Wr_Data = '0;
        model_reset();

        // Reset and idle
        do_reset(3, 1'b1);
        chk("reset_kbsr", KBSR, 16'h0000);
        chk("reset_kbdr", KBDR, 16'h0000);
        idle(20);
        chk("idle_kbsr", KBSR, 16'h0000);
        chk("idle_kbdr", KBDR, 16'h0000);
`ifdef KBD_IRQ_EN
        chk("idle_irq", {15'd0, Irq}, 16'h0000);
`endif

        // Single long press gives exactly one entry
        hold_low(10, 16'h0041);
        idle(D + 2);
        chk("press_kbsr", KBSR, 16'h8000);
        chk("press_kbdr", KBDR, 16'h0041);
        pop1();
        chk("press_one_entry", KBSR, 16'h0000);

        // Bounce shorter than the debounce window is ignored
        hold_low(3, 16'h1234);
        idle(1);
        hold_low(3, 16'h1234);
        idle(D + 2);
        chk("bounce_kbsr", KBSR, 16'h0000);

        // Five presses into a four-entry FIFO: overrun, ordered pops, write-clear
        for (int i = 1; i <= 5; i++) press(16'(i));
        chk("ovr_kbsr", KBSR, 16'hA000);
        chk("ovr_head", KBDR, 16'h0001);
        for (int i = 1; i <= 4; i++) begin
            pop1();
            chk("pop_head", KBDR, (i < 4) ? 16'(i + 1) : 16'h0000);
        end
        chk("drained_kbsr", KBSR, 16'h2000);
        chk("drained_kbdr", KBDR, 16'h0000);
        wr_kbsr(16'h0000);
        chk("ovr_clear", KBSR, 16'h0000);

        // Full FIFO, push and pop in the same cycle
        for (int i = 0; i < 4; i++) press(16'h0010 + 16'(i));
        chk("full_kbsr", KBSR, 16'h8000);
        hold_low(D, 16'h0099);
        tick(1'b0, 16'h0099, 1'b1, 1'b0, 16'h0000);
        chk("pushpop_kbsr", KBSR, 16'h8000);
        chk("pushpop_head", KBDR, 16'h0011);
        idle(D + 2);
        pop1(); chk("pp_head2", KBDR, 16'h0012);
        pop1(); chk("pp_head3", KBDR, 16'h0013);
        pop1(); chk("pp_tail", KBDR, 16'h0099);
        pop1(); chk("pp_empty", KBSR, 16'h0000);
        pop1();
        chk("pop_empty_kbsr", KBSR, 16'h0000);
        chk("pop_empty_kbdr", KBDR, 16'h0000);

`ifdef KBD_IRQ_EN
        // Interrupt enable and Irq timing
        wr_kbsr(16'h4000);
        chk("ie_set", KBSR, 16'h4000);
        press(16'h0007);
        chk("irq_kbsr", KBSR, 16'hC000);
        chk("irq_on", {15'd0, Irq}, 16'h0001);
        pop1();
        chk("irq_pop_kbsr", KBSR, 16'h4000);
        idle(1);
        chk("irq_off", {15'd0, Irq}, 16'h0000);
        wr_kbsr(16'h0000);
`endif

        // Key held low through reset: one event after a full stable window
        hold_low(3, 16'h0055);
        do_reset(2, 1'b0);
        hold_low(D + 1, 16'h0077);
        chk("held_reset_kbsr", KBSR, 16'h8000);
        chk("held_reset_kbdr", KBDR, 16'h0077);
        idle(D + 2);
        pop1();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic key;
            int   len;
            key = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                tick(key, 16'($urandom),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 7) == 0),
                     16'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
